// File: rtl/cond_match_pkg.sv
// Shared types and helpers for the condition match detector.
// Holds the qualifier state encoding, the default reference values and a saturating increment.
// Pure declarations: no logic, no latency, no backpressure.
package cond_match_pkg;

  // Qualifier FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_MATCHED = 2'd2
  } qual_state_e;

  // Reset values for the programmable references
  localparam int unsigned DEF_A_REF = 2;
  localparam int unsigned DEF_C_REF = 0;

  // Add one unless the value has already reached the limit
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
    return (val >= lim) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cond_match_qual.sv
// Qualifier: run counter, IDLE/ARMING/MATCHED FSM and saturating hit counter.
// Latency: common_o is registered one cycle after the stage-1 sample; common_d is its next value.
// No backpressure; a bubble (v1_i=0) holds run/state and forces the output low for that cycle.
module cond_match_qual
  import cond_match_pkg::*;
#(
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v1_i,
  input  logic             m1_i,
  input  logic             restart_i,
  input  logic             clr_cnt_i,
  output logic             common_d_o,
  output logic             common_o,
  output logic [CNT_W-1:0] hit_cnt_o
);

  localparam int RUN_W = 8;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  qual_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             common_q, common_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  // Next-state for run length, qualifier state, common match and hit counter
  always_comb begin
    run_d    = run_q;
    state_d  = state_q;
    common_d = 1'b0;
    hit_d    = hit_q;
    if (restart_i) begin
      // Reference change: start the history from scratch
      run_d   = '0;
      state_d = ST_IDLE;
    end else if (v1_i) begin
      if (m1_i) begin
        run_d    = RUN_W'(sat_inc(32'(run_q), 32'(HOLD)));
        state_d  = (32'(run_d) == 32'(HOLD)) ? ST_MATCHED : ST_ARMING;
        common_d = (state_d == ST_MATCHED);
      end else begin
        run_d   = '0;
        state_d = ST_IDLE;
      end
    end
    if (clr_cnt_i) begin
      hit_d = '0;
    end else if (common_d) begin
      hit_d = CNT_W'(sat_inc(32'(hit_q), CNT_MAX));
    end
  end

  // Qualifier state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= '0;
      state_q  <= ST_IDLE;
      common_q <= 1'b0;
      hit_q    <= '0;
    end else begin
      run_q    <= run_d;
      state_q  <= state_d;
      common_q <= common_d;
      hit_q    <= hit_d;
    end
  end

  assign common_d_o = common_d;
  assign common_o   = common_q;
  assign hit_cnt_o  = hit_q;

endmodule

// File: rtl/cond_match_detector.sv
// Registered condition detector: (a==a_ref)&&(c==c_ref), debounced, qualified per flag, with hit counter.
// Latency 2 cycles sample-to-output at HOLD=1; no backpressure, in_valid=0 inserts an output-0 bubble.
// Optional sticky per-channel output when COND_MATCH_STICKY_EN is defined.
module cond_match_detector
  import cond_match_pkg::*;
#(
  parameter int A_W   = 3,
  parameter int C_W   = 2,
  parameter int NF    = 2,
  parameter int A_REF = DEF_A_REF,
  parameter int C_REF = DEF_C_REF,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [A_W-1:0]   cfg_a_ref,
  input  logic [C_W-1:0]   cfg_c_ref,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [C_W-1:0]   c,
  input  logic [NF-1:0]    f,
  input  logic             clr_cnt,
`ifdef COND_MATCH_STICKY_EN
  output logic [NF-1:0]    sticky,
`endif
  output logic             common_o,
  output logic [NF-1:0]    y_pos,
  output logic [NF-1:0]    y_neg,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [A_W-1:0] a_ref_q;
  logic [C_W-1:0] c_ref_q;
  logic           v1_q;
  logic           m1_q;
  logic [NF-1:0]  f1_q;
  logic           common_d;
  logic [NF-1:0]  y_pos_q, y_neg_q;

  // References and stage 1: one shared compare against the references held before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ref_q <= A_W'(A_REF);
      c_ref_q <= C_W'(C_REF);
      v1_q    <= 1'b0;
      m1_q    <= 1'b0;
      f1_q    <= '0;
    end else begin
      if (cfg_we) begin
        a_ref_q <= cfg_a_ref;
        c_ref_q <= cfg_c_ref;
      end
      v1_q <= in_valid;
      m1_q <= (a == a_ref_q) && (c == c_ref_q);
      f1_q <= f;
    end
  end

  cond_match_qual #(
    .HOLD  (HOLD),
    .CNT_W (CNT_W)
  ) u_qual (
    .clk        (clk),
    .rst        (rst),
    .v1_i       (v1_q),
    .m1_i       (m1_q),
    .restart_i  (cfg_we),
    .clr_cnt_i  (clr_cnt),
    .common_d_o (common_d),
    .common_o   (common_o),
    .hit_cnt_o  (hit_cnt)
  );

  // Per-channel fan-out, registered alongside common_o
  always_ff @(posedge clk) begin
    if (rst) begin
      y_pos_q <= '0;
      y_neg_q <= '0;
    end else begin
      y_pos_q <= common_d ? f1_q : '0;
      y_neg_q <= common_d ? ~f1_q : '0;
    end
  end

  assign y_pos = y_pos_q;
  assign y_neg = y_neg_q;

`ifdef COND_MATCH_STICKY_EN
  logic [NF-1:0] sticky_q;

  // Sticky flags set by y_pos, cleared by clr_cnt (clear wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (clr_cnt) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_q | (common_d ? f1_q : '0);
    end
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_cond_match_detector.sv
module tb_cond_match_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_a_ref;
  logic [1:0] cfg_c_ref;
  logic       in_valid;
  logic [2:0] a;
  logic [1:0] c;
  logic [1:0] f;
  logic       clr_cnt;

  logic       common1, common3;
  logic [1:0] ypos1, yneg1, ypos3, yneg3;
  logic [7:0] hit1;
  logic [1:0] hit3;
`ifdef COND_MATCH_STICKY_EN
  logic [1:0] sticky1, sticky3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Default build: HOLD=1, CNT_W=8
  cond_match_detector dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_a_ref(cfg_a_ref), .cfg_c_ref(cfg_c_ref),
    .in_valid(in_valid), .a(a), .c(c), .f(f), .clr_cnt(clr_cnt),
`ifdef COND_MATCH_STICKY_EN
    .sticky(sticky1),
`endif
    .common_o(common1), .y_pos(ypos1), .y_neg(yneg1), .hit_cnt(hit1)
  );

  // Debounced, narrow counter: HOLD=3, CNT_W=2
  cond_match_detector #(.HOLD(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_a_ref(cfg_a_ref), .cfg_c_ref(cfg_c_ref),
    .in_valid(in_valid), .a(a), .c(c), .f(f), .clr_cnt(clr_cnt),
`ifdef COND_MATCH_STICKY_EN
    .sticky(sticky3),
`endif
    .common_o(common3), .y_pos(ypos3), .y_neg(yneg3), .hit_cnt(hit3)
  );

  // Reference model: streak of consecutive valid matches, qualify once streak reaches HOLD
  int         hold_m [2] = '{1, 3};
  int         cmax_m [2] = '{255, 3};
  int         streak [2];
  int         hits   [2];
  logic       e_com  [2];
  logic [1:0] e_pos  [2];
  logic [1:0] e_neg  [2];
  logic [1:0] e_stk  [2];
  logic       s1_v, s1_m;
  logic [1:0] s1_f;
  logic [2:0] ref_a;
  logic [1:0] ref_c;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      streak[k] = 0; hits[k] = 0; e_com[k] = 1'b0;
      e_pos[k] = 2'b00; e_neg[k] = 2'b00; e_stk[k] = 2'b00;
    end
    s1_v = 1'b0; s1_m = 1'b0; s1_f = 2'b00;
    ref_a = 3'd2; ref_c = 2'd0;
  endtask

  task automatic model_edge();
    logic q;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      q = 1'b0;
      if (cfg_we) streak[k] = 0;
      else if (s1_v) begin
        if (s1_m) begin
          streak[k] = streak[k] + 1;
          q = (streak[k] >= hold_m[k]);
        end else streak[k] = 0;
      end
      e_com[k] = q;
      e_pos[k] = q ? s1_f : 2'b00;
      e_neg[k] = q ? ~s1_f : 2'b00;
      if (clr_cnt) hits[k] = 0;
      else if (q && hits[k] < cmax_m[k]) hits[k] = hits[k] + 1;
      e_stk[k] = clr_cnt ? 2'b00 : (e_stk[k] | e_pos[k]);
    end
    s1_v = in_valid;
    s1_m = (a == ref_a) && (c == ref_c);
    s1_f = f;
    if (cfg_we) begin
      ref_a = cfg_a_ref;
      ref_c = cfg_c_ref;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("common1", 8'(common1), 8'(e_com[0]));
    chk("ypos1",   8'(ypos1),   8'(e_pos[0]));
    chk("yneg1",   8'(yneg1),   8'(e_neg[0]));
    chk("hit1",    hit1,        8'(hits[0]));
    chk("common3", 8'(common3), 8'(e_com[1]));
    chk("ypos3",   8'(ypos3),   8'(e_pos[1]));
    chk("yneg3",   8'(yneg3),   8'(e_neg[1]));
    chk("hit3",    8'(hit3),    8'(hits[1]));
`ifdef COND_MATCH_STICKY_EN
    chk("sticky1", 8'(sticky1), 8'(e_stk[0]));
    chk("sticky3", 8'(sticky3), 8'(e_stk[1]));
`endif
  endtask

  // One clock: drive on the falling edge, model at the rising edge, check 1 time unit later
  task automatic cyc(input logic v, input logic [2:0] aa, input logic [1:0] cc, input logic [1:0] ff,
                     input logic we, input logic [2:0] wa, input logic [1:0] wc,
                     input logic clr, input logic r);
    @(negedge clk);
    in_valid = v; a = aa; c = cc; f = ff;
    cfg_we = we; cfg_a_ref = wa; cfg_c_ref = wc;
    clr_cnt = clr; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic samp(input logic v, input logic [2:0] aa, input logic [1:0] cc, input logic [1:0] ff);
    cyc(v, aa, cc, ff, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic       v, we, clr, r;
    logic [2:0] aa, wa;
    logic [1:0] cc, ff, wc;

    rst = 1'b1; cfg_we = 1'b0; cfg_a_ref = '0; cfg_c_ref = '0;
    in_valid = 1'b0; a = '0; c = '0; f = '0; clr_cnt = 1'b0;
    model_reset();

    // Reset state
    cyc(1'b0, 3'd0, 2'd0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 2'd0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);

    // Single match at default references, HOLD=1 qualifies two cycles later
    samp(1'b1, 3'd2, 2'd0, 2'b01);
    repeat (3) samp(1'b0, 3'd0, 2'd0, 2'b00);

    // Five consecutive matches: HOLD=3 instance qualifies on the last three
    repeat (5) samp(1'b1, 3'd2, 2'd0, 2'b10);
    repeat (2) samp(1'b0, 3'd0, 2'd0, 2'b00);

    // Mismatch in the middle restarts the run
    samp(1'b1, 3'd2, 2'd0, 2'b11);
    samp(1'b1, 3'd3, 2'd0, 2'b11);
    repeat (2) samp(1'b1, 3'd2, 2'd0, 2'b11);
    samp(1'b1, 3'd0, 2'd0, 2'b11);
    repeat (2) samp(1'b0, 3'd0, 2'd0, 2'b00);

    // Bubble between matches holds the run
    repeat (2) samp(1'b1, 3'd2, 2'd0, 2'b01);
    samp(1'b0, 3'd2, 2'd0, 2'b01);
    samp(1'b1, 3'd2, 2'd0, 2'b01);
    repeat (2) samp(1'b0, 3'd0, 2'd0, 2'b00);

    // Reference change mid-run, then new refs match and old refs do not
    repeat (2) samp(1'b1, 3'd2, 2'd0, 2'b10);
    cyc(1'b1, 3'd2, 2'd0, 2'b10, 1'b1, 3'd5, 2'd1, 1'b0, 1'b0);
    repeat (4) samp(1'b1, 3'd5, 2'd1, 2'b10);
    repeat (2) samp(1'b1, 3'd2, 2'd0, 2'b10);

    // Continuous match saturates the 2-bit counter, then clear coincident with a match
    repeat (6) samp(1'b1, 3'd5, 2'd1, 2'b01);
    cyc(1'b1, 3'd5, 2'd1, 2'b01, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
    repeat (2) samp(1'b1, 3'd5, 2'd1, 2'b01);

    // Reset while matched: outputs drop, references return to 2/0
    cyc(1'b1, 3'd5, 2'd1, 2'b01, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    repeat (4) samp(1'b1, 3'd2, 2'd0, 2'b11);
    repeat (2) samp(1'b1, 3'd5, 2'd1, 2'b11);

    // Randomized traffic, biased towards the current references
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      we  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 7) != 0);
      ff  = 2'($urandom_range(0, 3));
      wa  = 3'($urandom_range(0, 7));
      wc  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        aa = ref_a; cc = ref_c;
      end else begin
        aa = 3'($urandom_range(0, 7));
        cc = 2'($urandom_range(0, 3));
      end
      cyc(v, aa, cc, ff, we, wa, wc, clr, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
